et_sbc: RTL and testbench
=========================

Name: et_sbc

Overview:
- Early-terminating stream-to-binary converter: counts ones in a stochastic bitstream `z` and returns a TW-bit binary estimate.
- Conversion stops at one of three points:
  - a programmed maximum stream length 2^prec,
  - an upstream end-of-stream signal (`src_done`, e.g. from the progressive-precision SNG),
  - or, when enabled, a stability check at power-of-two checkpoints.
- Sits at the output of a stochastic datapath (e.g. edge-detector core) and hands results downstream over a valid/ready handshake.

Parameters:
- TW, 5, result width; maximum stream length is 2^TW.
- MIN_K, 2, first checkpoint exponent; 1 <= MIN_K < TW.
- KW, $clog2(TW+1), width of exponent fields (derived, localparam).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin conversion; accepted only in IDLE.
- prec  in  KW  log2 of maximum stream length; latched at start.
- et_en  in  1  enable stability early termination; latched at start.
- et_tol  in  TW  stability tolerance; latched at start.
- z  in  1  stochastic input bit.
- z_valid  in  1  z is valid this cycle.
- src_done  in  1  upstream stream finished.
- bz  out  TW  binary result.
- bz_valid  out  1  result valid.
- bz_ready  in  1  downstream accepts result.
- len_used  out  KW  exponent of checkpoint that produced bz; 0 if none reached.
- busy  out  1  high in ACC or HOLD.

Behaviour:
- Reset (asynchronous, rst_n low):
  - state=IDLE; bz=0, bz_valid=0, len_used=0, busy=0.
  - All counters and latches cleared; takes effect immediately, including mid-conversion.
- States: IDLE, ACC, HOLD.
- IDLE -> ACC when start=1:
  - latch prec clamped to [MIN_K, TW], plus et_en and et_tol;
  - clear cnt (TW+1 bits), ones (TW+1 bits) and prev_est (TW bits); set lastk=0.
- ACC, per cycle with z_valid=1:
  - cnt_n = cnt+1 and ones_n = ones+z, both registered.
- Checkpoint: occurs when cnt_n == 2^j for some j in [MIN_K, TW].
  - E_j = ones_n << (TW-j), saturated to 2^TW-1 when ones_n == 2^j.
  - Register prev_est=E_j and lastk=j.
- Termination, evaluated on the accepted bit (priority order; first match sets bz/len_used):
  - (a) cnt_n == 2^prec: bz=E_prec.
  - (b) et_en=1, a checkpoint with j > MIN_K, and |E_j - prev_est(old)| <= et_tol: bz=E_j.
  - (c) src_done=1: bz=E_j if this bit is a checkpoint, else prev_est; len_used=lastk (updated).
  - For (a) and (b), len_used=j.
- src_done=1 with z_valid=0 in ACC:
  - terminate with bz=prev_est, len_used=lastk.
  - bz=0, len_used=0 if no checkpoint has been reached.
- On termination: move to HOLD and set bz_valid=1 on the next clock edge (1-cycle latency after the terminating bit).
- HOLD:
  - bz, len_used and bz_valid are held stable.
  - z_valid, src_done and start are ignored.
  - If bz_ready=1: bz_valid drops on the next edge and state returns to IDLE. bz keeps its value until the next termination.
- bz_ready while not in HOLD: no effect.
- busy = (state != IDLE).
- Arithmetic:
  - The |difference| is computed on TW+1 bits, unsigned.
  - The shift uses the constant (TW-j) selected per checkpoint; implement as a mux over j, no variable barrel shifter beyond TW positions.

Decomposition:
- Shared package entries:
  - state enum typedef (IDLE/ACC/HOLD);
  - a function scale_est(ones, j, TW) doing shift plus saturation, reused by the self-checking model.
- One sub-module, et_checkpoint: combinational checkpoint detect (cnt_n power-of-two in range), E_j computation and tolerance compare.
- Counters, FSM and handshake stay in et_sbc.

Test Plan (TW=5, MIN_K=2):
1. prec=5, et_en=0, 32 ones -> bz=31 (saturated), len_used=5; bz_valid rises the cycle after bit 32.
2. prec=4, et_en=0, 16 bits alternating 1,0 -> ones=8, bz=16, len_used=4.
3. prec=5, et_en=1, et_tol=0, repeating 0,1:
   - cnt=4 gives E=16 (checkpoint, no compare);
   - cnt=8 gives E=16 -> terminate at bit 8, bz=16, len_used=3.
4. prec=5, bits 1,1,0,1,1,0 then src_done with z_valid=0 -> last checkpoint at cnt=4 (ones=3), bz=24, len_used=2.
5. Complete test 2, hold bz_ready=0 for 5 cycles while toggling z_valid and start -> bz_valid and bz=16 stay stable. bz_ready=1 -> bz_valid low and IDLE next cycle; a new start is then accepted.
6. rst_n low for 1 cycle mid-ACC (after 10 bits) -> busy, bz_valid and len_used are 0 immediately. Rerunning test 2 then gives bz=16.

Source files
------------

// File: rtl/et_sbc_pkg.sv
// Shared types and helpers for the early-terminating stream-to-binary converter.
// scale_est is also used as the reference for checkpoint estimates.
package et_sbc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    // Scale a ones count seen over 2^j bits up to a tw-bit estimate.
    // An all-ones stream saturates to the largest representable value.
    function automatic logic [31:0] scale_est(input logic [31:0] ones, input int j, input int tw);
        if (ones == (32'd1 << j))
            return (32'd1 << tw) - 32'd1;
        return ones << (tw - j);
    endfunction

endpackage

// File: rtl/et_sbc_checkpoint.sv
// Combinational checkpoint detection, estimate scaling and stability compare.
// Each candidate exponent uses its own constant shift, so the result is a mux over j.
module et_checkpoint
    import et_sbc_pkg::*;
#(
    parameter int TW    = 5,
    parameter int MIN_K = 2,
    parameter int KW    = $clog2(TW + 1)
) (
    input  logic [TW:0]   i_cnt_n,
    input  logic [TW:0]   i_ones_n,
    input  logic [TW-1:0] i_prev_est,
    input  logic [TW-1:0] i_et_tol,
    output logic          o_is_cp,
    output logic [KW-1:0] o_j,
    output logic [TW-1:0] o_est,
    output logic          o_in_tol
);

    logic [TW:0] w_a;
    logic [TW:0] w_b;
    logic [TW:0] w_diff;

    always_comb begin
        o_is_cp = 1'b0;
        o_j     = '0;
        o_est   = '0;
        for (int k = MIN_K; k <= TW; k++) begin
            if (i_cnt_n == (TW+1)'(1 << k)) begin
                o_is_cp = 1'b1;
                o_j     = KW'(k);
                o_est   = TW'(scale_est(32'(i_ones_n), k, TW));
            end
        end
    end

    // Unsigned absolute difference against the previous checkpoint estimate.
    assign w_a      = {1'b0, o_est};
    assign w_b      = {1'b0, i_prev_est};
    assign w_diff   = (w_a >= w_b) ? (w_a - w_b) : (w_b - w_a);
    assign o_in_tol = (w_diff <= {1'b0, i_et_tol});

endmodule

// File: rtl/et_sbc.sv
// Stream-to-binary converter: counts ones in z and stops at max length, on
// upstream done, or when consecutive power-of-two checkpoints agree within tolerance.
module et_sbc
    import et_sbc_pkg::*;
#(
    parameter  int TW    = 5,
    parameter  int MIN_K = 2,
    localparam int KW    = $clog2(TW + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [KW-1:0] prec,
    input  logic          et_en,
    input  logic [TW-1:0] et_tol,
    input  logic          z,
    input  logic          z_valid,
    input  logic          src_done,
    output logic [TW-1:0] bz,
    output logic          bz_valid,
    input  logic          bz_ready,
    output logic [KW-1:0] len_used,
    output logic          busy,
    output logic [1:0]    dbg_state
);

    // Handshake: bz/len_used are stable while bz_valid is high; a result is
    // consumed on the edge where bz_valid && bz_ready, after which bz_valid drops.

    state_t        r_state;
    state_t        w_state_nxt;
    logic [KW-1:0] r_prec;
    logic          r_et_en;
    logic [TW-1:0] r_et_tol;
    logic [TW:0]   r_cnt;
    logic [TW:0]   r_ones;
    logic [TW-1:0] r_prev_est;
    logic [KW-1:0] r_lastk;
    logic [TW-1:0] r_bz;
    logic          r_bz_valid;
    logic [KW-1:0] r_len_used;

    logic [KW-1:0] w_prec_cl;
    logic [TW:0]   w_cnt_n;
    logic [TW:0]   w_ones_n;
    logic          w_is_cp;
    logic [KW-1:0] w_j;
    logic [TW-1:0] w_est;
    logic          w_in_tol;
    logic          w_term;
    logic [TW-1:0] w_bz_nxt;
    logic [KW-1:0] w_len_nxt;

    assign w_cnt_n  = r_cnt + 1'b1;
    assign w_ones_n = r_ones + {{TW{1'b0}}, z};

    always_comb begin
        w_prec_cl = prec;
        if (prec < KW'(MIN_K))
            w_prec_cl = KW'(MIN_K);
        else if (prec > KW'(TW))
            w_prec_cl = KW'(TW);
    end

    et_checkpoint #(.TW(TW), .MIN_K(MIN_K), .KW(KW)) u_cp (
        .i_cnt_n    (w_cnt_n),
        .i_ones_n   (w_ones_n),
        .i_prev_est (r_prev_est),
        .i_et_tol   (r_et_tol),
        .o_is_cp    (w_is_cp),
        .o_j        (w_j),
        .o_est      (w_est),
        .o_in_tol   (w_in_tol)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_term      = 1'b0;
        w_bz_nxt    = r_bz;
        w_len_nxt   = r_len_used;
        case (r_state)
            ST_IDLE: if (start) w_state_nxt = ST_ACC;
            ST_ACC: begin
                if (z_valid) begin
                    if (w_is_cp && (w_j == r_prec)) begin
                        w_term = 1'b1; w_bz_nxt = w_est; w_len_nxt = w_j;
                    end else if (r_et_en && w_is_cp && (w_j > KW'(MIN_K)) && w_in_tol) begin
                        w_term = 1'b1; w_bz_nxt = w_est; w_len_nxt = w_j;
                    end else if (src_done) begin
                        w_term    = 1'b1;
                        w_bz_nxt  = w_is_cp ? w_est : r_prev_est;
                        w_len_nxt = w_is_cp ? w_j   : r_lastk;
                    end
                end else if (src_done) begin
                    w_term = 1'b1; w_bz_nxt = r_prev_est; w_len_nxt = r_lastk;
                end
                if (w_term) w_state_nxt = ST_HOLD;
            end
            ST_HOLD: if (bz_ready) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prec <= '0; r_et_en <= 1'b0; r_et_tol <= '0;
            r_cnt <= '0; r_ones <= '0; r_prev_est <= '0; r_lastk <= '0;
            r_bz <= '0; r_bz_valid <= 1'b0; r_len_used <= '0;
        end else begin
            if ((r_state == ST_IDLE) && start) begin
                r_prec <= w_prec_cl; r_et_en <= et_en; r_et_tol <= et_tol;
                r_cnt <= '0; r_ones <= '0; r_prev_est <= '0; r_lastk <= '0;
            end
            if ((r_state == ST_ACC) && z_valid) begin
                r_cnt  <= w_cnt_n;
                r_ones <= w_ones_n;
                if (w_is_cp) begin
                    r_prev_est <= w_est;
                    r_lastk    <= w_j;
                end
            end
            if (w_term) begin
                r_bz       <= w_bz_nxt;
                r_len_used <= w_len_nxt;
                r_bz_valid <= 1'b1;
            end
            if ((r_state == ST_HOLD) && bz_ready)
                r_bz_valid <= 1'b0;
        end
    end

    assign bz        = r_bz;
    assign bz_valid  = r_bz_valid;
    assign len_used  = r_len_used;
    assign busy      = (r_state != ST_IDLE);
    assign dbg_state = r_state;

endmodule

// File: tb/tb_et_sbc.sv
// Directed bench for et_sbc with TW=5, MIN_K=2: vector table plus hand sequences
// for hold/backpressure and asynchronous reset.
module tb_et_sbc;

    localparam int TW = 5;
    localparam int KW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [KW-1:0] prec = '0;
    logic          et_en = 1'b0;
    logic [TW-1:0] et_tol = '0;
    logic          z = 1'b0;
    logic          z_valid = 1'b0;
    logic          src_done = 1'b0;
    logic [TW-1:0] bz;
    logic          bz_valid;
    logic          bz_ready = 1'b0;
    logic [KW-1:0] len_used;
    logic          busy;
    logic [1:0]    dbg_state;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [KW-1:0] prec;
        logic          et_en;
        logic [TW-1:0] tol;
        logic [31:0]   bits;      // bit i is the i-th stream bit
        int            nbits;
        int            done_mode; // 0 none, 1 src_done after bits, 2 with last bit
        logic [TW-1:0] exp_bz;
        logic [KW-1:0] exp_len;
    } vec_t;

    vec_t vecs[11];

    always #5 clk = ~clk;

    et_sbc #(.TW(TW), .MIN_K(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .prec(prec), .et_en(et_en),
        .et_tol(et_tol), .z(z), .z_valid(z_valid), .src_done(src_done),
        .bz(bz), .bz_valid(bz_valid), .bz_ready(bz_ready), .len_used(len_used),
        .busy(busy), .dbg_state(dbg_state)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_vec(input vec_t v, input int idx);
        logic early;
        start = 1'b1; prec = v.prec; et_en = v.et_en; et_tol = v.tol;
        tick();
        start = 1'b0;
        check($sformatf("v%0d_busy", idx), 32'(busy), 32'd1);
        early = 1'b0;
        for (int i = 0; i < v.nbits; i++) begin
            z = v.bits[i]; z_valid = 1'b1;
            src_done = (v.done_mode == 2) && (i == v.nbits - 1);
            tick();
            z = 1'b0; z_valid = 1'b0; src_done = 1'b0;
            if ((i < v.nbits - 1) && bz_valid) early = 1'b1;
        end
        check($sformatf("v%0d_early_valid", idx), 32'(early), 32'd0);
        if (v.done_mode == 1) begin
            check($sformatf("v%0d_pre_done_valid", idx), 32'(bz_valid), 32'd0);
            src_done = 1'b1;
            tick();
            src_done = 1'b0;
        end
        check($sformatf("v%0d_valid", idx), 32'(bz_valid), 32'd1);
        check($sformatf("v%0d_bz", idx), 32'(bz), 32'(v.exp_bz));
        check($sformatf("v%0d_len", idx), 32'(len_used), 32'(v.exp_len));
    endtask

    task automatic release_result(input logic [TW-1:0] exp_bz, input string tag);
        bz_ready = 1'b1;
        tick();
        bz_ready = 1'b0;
        check({tag, "_valid_drop"}, 32'(bz_valid), 32'd0);
        check({tag, "_idle"}, 32'(busy), 32'd0);
        check({tag, "_bz_kept"}, 32'(bz), 32'(exp_bz));
    endtask

    initial begin
        //            prec  et    tol   bits           n   dm  bz     len
        vecs[0]  = '{3'd5, 1'b0, 5'd0, 32'hFFFF_FFFF, 32, 0, 5'd31, 3'd5}; // saturate at full length
        vecs[1]  = '{3'd4, 1'b0, 5'd0, 32'h0000_5555, 16, 0, 5'd16, 3'd4}; // 1,0 alternating
        vecs[2]  = '{3'd5, 1'b1, 5'd0, 32'h0000_00AA,  8, 0, 5'd16, 3'd3}; // stable at j=3
        vecs[3]  = '{3'd5, 1'b0, 5'd0, 32'h0000_001B,  6, 1, 5'd24, 3'd2}; // done, z_valid=0
        vecs[4]  = '{3'd0, 1'b0, 5'd0, 32'h0000_000D,  4, 0, 5'd24, 3'd2}; // prec clamped up to 2
        vecs[5]  = '{3'd7, 1'b0, 5'd0, 32'h0000_0000, 32, 0, 5'd0,  3'd5}; // prec clamped down to 5
        vecs[6]  = '{3'd5, 1'b0, 5'd0, 32'h0000_0003,  2, 1, 5'd0,  3'd0}; // done before any checkpoint
        vecs[7]  = '{3'd5, 1'b0, 5'd0, 32'h0000_008F,  8, 2, 5'd20, 3'd3}; // done on checkpoint bit
        vecs[8]  = '{3'd5, 1'b0, 5'd0, 32'h0000_0019,  5, 2, 5'd16, 3'd2}; // done off checkpoint
        vecs[9]  = '{3'd5, 1'b1, 5'd4, 32'h0000_0051,  8, 0, 5'd12, 3'd3}; // |12-8|=4 within tol
        vecs[10] = '{3'd5, 1'b1, 5'd3, 32'h0000_1551, 16, 0, 5'd12, 3'd4}; // tol 3 misses, j=4 matches

        // Reset state
        tick(); tick();
        check("rst_bz", 32'(bz), 32'd0);
        check("rst_valid", 32'(bz_valid), 32'd0);
        check("rst_len", 32'(len_used), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        tick();

        for (int n = 0; n < 11; n++) begin
            apply_vec(vecs[n], n);
            release_result(vecs[n].exp_bz, $sformatf("v%0d", n));
        end

        // Result held under backpressure while other inputs toggle
        apply_vec(vecs[1], 100);
        for (int c = 0; c < 5; c++) begin
            z = 1'b1; z_valid = c[0]; start = ~c[0]; src_done = 1'b1;
            tick();
            check($sformatf("hold%0d_valid", c), 32'(bz_valid), 32'd1);
            check($sformatf("hold%0d_bz", c), 32'(bz), 32'd16);
            check($sformatf("hold%0d_len", c), 32'(len_used), 32'd4);
        end
        z = 1'b0; z_valid = 1'b0; start = 1'b0; src_done = 1'b0;
        release_result(5'd16, "hold_rel");
        apply_vec(vecs[2], 101);
        release_result(5'd16, "after_hold");

        // Asynchronous reset in the middle of accumulation
        start = 1'b1; prec = 3'd4; et_en = 1'b0; et_tol = '0;
        tick();
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            z = i[0]; z_valid = 1'b1;
            tick();
        end
        z_valid = 1'b0; z = 1'b0;
        check("mid_busy_before", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_valid", 32'(bz_valid), 32'd0);
        check("mid_rst_len", 32'(len_used), 32'd0);
        check("mid_rst_bz", 32'(bz), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        apply_vec(vecs[1], 102);
        release_result(5'd16, "after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
